ws_pixel_transmitter: RTL
=========================

// Module: ws_pixel_transmitter
// PURPOSE
//   Parametrised successor to the single-bit LED-stripe transmitter. Accepts whole pixel
//   words over a valid/ready stream and serialises them MSB-first as a one-wire NRZ
//   pulse-width stream on the LED stripe pin.
//   Pixel width and all pulse timings are parameters.
//   Ends a frame with a low latch (reset) period when the pixel flagged last has been sent.
//   Sits between the frame buffer / pixel fetcher and the stripe output pin.
// PARAMETERS
//   PIXEL_W  24    bits per pixel (24 = GRB, 32 = GRBW); >= 2
//   T_LONG   20    clk cycles of the long phase (high of '1', low of '0')
//   T_SHORT  10    clk cycles of the short phase (high of '0', low of '1'); 1 <= T_SHORT < T_LONG
//   T_RESET  1250  clk cycles of the latch-low period (50 us at 25 MHz)
//   TIMER_W  16    phase timer width; must hold max(T_LONG,T_RESET)
//   CNT_W    10    width of the pixel counter
// PORTS
//   clk             in   1        system clock
//   rstn            in   1        asynchronous reset, active low
//   s_valid         in   1        pixel word valid
//   s_ready         out  1        block can take a pixel this cycle
//   s_data          in   PIXEL_W  pixel word, MSB sent first
//   s_last          in   1        this pixel ends the frame
//   led_stripe_pin  out  1        serial output, registered
//   busy            out  1        high in every state except IDLE
//   frame_done      out  1        1-cycle pulse at end of latch period
//   pix_cnt         out  CNT_W    pixels accepted in current frame; saturates at all-ones
//   underrun        out  1        1-cycle pulse, see CONFIGURATION
// BEHAVIOUR
//   Reset (async): led_stripe_pin=0, s_ready=0, busy=1, frame_done=0, pix_cnt=0, underrun=0.
//     State goes to LATCH with timer=T_RESET. frame_done is suppressed for this post-reset latch.
//   Handshake: a transfer occurs on any clk edge with s_valid&&s_ready.
//     s_data/s_last are captured into the shift register and last_r. pix_cnt is incremented.
//   States:
//     LATCH: pin=0, s_ready=0, T_RESET cycles.
//       Goes to IDLE, with frame_done pulsing in the first IDLE cycle (not after reset).
//       pix_cnt clears together with the frame_done pulse.
//     IDLE: pin=0, s_ready=1, busy=0. On transfer -> HIGH.
//     HIGH: pin=1 for T_LONG cycles (bit=1) or T_SHORT cycles (bit=0). Then -> LOW.
//     LOW: pin=0 for T_SHORT cycles (bit=1) or T_LONG cycles (bit=0). At the end of LOW:
//       - bits remaining: shift left, decrement bit_cnt, go to HIGH.
//       - final bit with last_r=1: go to LATCH.
//       - final bit with last_r=0: s_ready=1 in the final LOW cycle only.
//         If a transfer occurs -> HIGH with no gap. Otherwise -> WAIT.
//     WAIT: pin=0, s_ready=1, busy=1. On transfer -> HIGH.
//   Latency: pin rises on the first clk edge after the transfer edge.
//   Timing: every bit period is exactly T_LONG+T_SHORT cycles.
//     Back-to-back pixels are contiguous, so a pixel lasts PIXEL_W*(T_LONG+T_SHORT) cycles.
//   s_ready is 0 in HIGH, in LATCH, and in every LOW cycle except the final cycle of the final bit.
//   s_last is ignored unless a transfer occurs in the same cycle.
//   A frame of one pixel is legal.
//   A WAIT longer than the stripe's latch time is the user's responsibility; the block does not time it.
//   Reset mid-operation: the pixel being shifted is discarded, no frame_done is issued,
//     and the post-reset LATCH runs in full.
// CONFIGURATION
//   WS_UNDERRUN_DET_EN defined:
//     underrun pulses for 1 cycle on entry to WAIT (mid-frame starvation).
//   Not defined: underrun is tied to 0, no extra logic is built, and the port remains.
// TESTING
//   1. Reset: rstn low 2 cycles, then high
//      -> pin=0 and s_ready=0 for 1250 cycles; then s_ready=1, busy=0, no frame_done.
//   2. Single pixel 24'hA500FF, s_last=1
//      -> 24 bits, each '1' = 20 high + 10 low and each '0' = 10 high + 20 low;
//         720 cycles of data, then 1250 cycles low;
//         frame_done pulses once with pix_cnt=1, and pix_cnt=0 in the next cycle.
//   3. Three pixels with s_valid held high, third with s_last=1
//      -> 2160 contiguous cycles with no gap;
//         s_ready high for exactly 1 cycle at each pixel boundary; pix_cnt reaches 3.
//   4. Second pixel presented 30 cycles late, s_last=0
//      -> pin low for 30 extra cycles, busy=1;
//         underrun pulses once with the macro defined and stays 0 without it.
//   5. PIXEL_W=32, pixel 32'h80000001, s_last=1
//      -> 960 data cycles; bits 31 and 0 are 20-cycle highs, the other 30 bits are 10-cycle highs.
//   6. rstn asserted mid-bit during HIGH
//      -> pin=0 immediately (async); no frame_done;
//         after release 1250 low cycles, then IDLE with pix_cnt=0.

Source files
------------

// File: rtl/ws_pixel_transmitter.sv
// Purpose: serialise pixel words MSB-first onto a one-wire NRZ pulse-width LED stripe pin.
// Latency: the pin is high in the cycle right after the handshake cycle; back-to-back pixels have no gap.
// Backpressure: s_ready is high only in IDLE, WAIT, and the final LOW cycle of a pixel that is not last.
//
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   s_valid/s_ready         pixel stream handshake
//   s_data, s_last          pixel word (MSB sent first), end-of-frame flag
//   led_stripe_pin          registered serial output
//   busy                    high in every state except IDLE
//   frame_done              1-cycle pulse in the first IDLE cycle after a frame's latch period
//   pix_cnt                 pixels accepted in the current frame, saturating
//   underrun                1-cycle pulse on entry to WAIT
//
// Optional build macro WS_UNDERRUN_DET_EN enables underrun detection;
// without it underrun is tied low and no logic is built for it.
module ws_pixel_transmitter #(
   parameter int PIXEL_W = 24,
   parameter int T_LONG  = 20,
   parameter int T_SHORT = 10,
   parameter int T_RESET = 1250,
   parameter int TIMER_W = 16,
   parameter int CNT_W   = 10
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [PIXEL_W-1:0] s_data,
   input  logic               s_last,
   output logic               led_stripe_pin,
   output logic               busy,
   output logic               frame_done,
   output logic [CNT_W-1:0]   pix_cnt,
   output logic               underrun
);

   localparam int BIT_W = $clog2(PIXEL_W);

   // Timer holds "cycles left in this phase minus one"; a phase ends when it reads zero.
   localparam logic [TIMER_W-1:0] LONG_M1  = TIMER_W'(T_LONG - 1);
   localparam logic [TIMER_W-1:0] SHORT_M1 = TIMER_W'(T_SHORT - 1);
   localparam logic [TIMER_W-1:0] RESET_M1 = TIMER_W'(T_RESET - 1);
   localparam logic [BIT_W-1:0]   LAST_BIT = BIT_W'(PIXEL_W - 1);

   typedef enum logic [2:0] {
      LATCH = 3'd0,
      IDLE  = 3'd1,
      HIGH  = 3'd2,
      LOW   = 3'd3,
      WAIT  = 3'd4
   } state_t;

   state_t             state;
   logic [TIMER_W-1:0] timer;
   logic [PIXEL_W-1:0] shreg;
   logic [BIT_W-1:0]   bit_cnt;
   logic               last_r;
   logic               post_rst;   // suppresses frame_done after the reset latch

   logic               xfer;
   logic               frame_cont;
   logic [CNT_W-1:0]   pix_base;
   logic [CNT_W-1:0]   pix_inc;

   function automatic logic [TIMER_W-1:0] hi_m1(input logic b);
      return b ? LONG_M1 : SHORT_M1;
   endfunction

   function automatic logic [TIMER_W-1:0] lo_m1(input logic b);
      return b ? SHORT_M1 : LONG_M1;
   endfunction

   // s_ready is only ever high where a new pixel may start, so a transfer
   // can take priority over whatever state we are in.
   assign xfer       = s_valid & s_ready;
   // Final bit of a pixel that does not end the frame: next pixel may follow directly.
   assign frame_cont = (bit_cnt == '0) & ~last_r;

   // A transfer in the frame_done cycle starts a new frame, so the old count is dropped.
   always_comb begin
      pix_base = frame_done ? '0 : pix_cnt;
      pix_inc  = (&pix_base) ? pix_base : pix_base + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= LATCH;
         timer          <= RESET_M1;
         shreg          <= '0;
         bit_cnt        <= '0;
         last_r         <= 1'b0;
         post_rst       <= 1'b1;
         led_stripe_pin <= 1'b0;
         s_ready        <= 1'b0;
         busy           <= 1'b1;
         frame_done     <= 1'b0;
         pix_cnt        <= '0;
`ifdef WS_UNDERRUN_DET_EN
         underrun       <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
`ifdef WS_UNDERRUN_DET_EN
         underrun   <= 1'b0;
`endif
         if (xfer) begin
            state          <= HIGH;
            shreg          <= s_data;
            last_r         <= s_last;
            bit_cnt        <= LAST_BIT;
            timer          <= hi_m1(s_data[PIXEL_W-1]);
            led_stripe_pin <= 1'b1;
            s_ready        <= 1'b0;
            busy           <= 1'b1;
            pix_cnt        <= pix_inc;
         end else begin
            case (state)
               LATCH: begin
                  if (timer == '0) begin
                     state      <= IDLE;
                     s_ready    <= 1'b1;
                     busy       <= 1'b0;
                     frame_done <= ~post_rst;
                     post_rst   <= 1'b0;
                  end else begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               IDLE: begin
                  // Count stays visible during the frame_done cycle, clears after it.
                  if (frame_done) pix_cnt <= '0;
               end
               HIGH: begin
                  if (timer == '0) begin
                     state          <= LOW;
                     led_stripe_pin <= 1'b0;
                     timer          <= lo_m1(shreg[PIXEL_W-1]);
                     // A one-cycle LOW phase is already the final cycle.
                     s_ready        <= (lo_m1(shreg[PIXEL_W-1]) == '0) & frame_cont;
                  end else begin
                     timer <= timer - TIMER_W'(1);
                  end
               end
               LOW: begin
                  if (timer == '0) begin
                     if (bit_cnt != '0) begin
                        state          <= HIGH;
                        shreg          <= {shreg[PIXEL_W-2:0], 1'b0};
                        bit_cnt        <= bit_cnt - BIT_W'(1);
                        timer          <= hi_m1(shreg[PIXEL_W-2]);
                        led_stripe_pin <= 1'b1;
                        s_ready        <= 1'b0;
                     end else if (last_r) begin
                        state   <= LATCH;
                        timer   <= RESET_M1;
                        s_ready <= 1'b0;
                     end else begin
                        // Starved mid-frame: hold the line low until the next pixel.
                        state    <= WAIT;
                        s_ready  <= 1'b1;
`ifdef WS_UNDERRUN_DET_EN
                        underrun <= 1'b1;
`endif
                     end
                  end else begin
                     timer   <= timer - TIMER_W'(1);
                     s_ready <= (timer == TIMER_W'(1)) & frame_cont;
                  end
               end
               WAIT: begin
                  s_ready <= 1'b1;
               end
               default: begin
                  state          <= LATCH;
                  timer          <= RESET_M1;
                  led_stripe_pin <= 1'b0;
                  s_ready        <= 1'b0;
                  busy           <= 1'b1;
               end
            endcase
         end
      end
   end

`ifndef WS_UNDERRUN_DET_EN
   assign underrun = 1'b0;
`endif

endmodule
